// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the register-file write port
//
// Two write-back requesters (req0 = ALU result, req1 = load data) share the
// single register-file write port. The winning write is registered for one
// cycle before it drives A3/WD/RegWrite. A pending-write scoreboard (Busy)
// tracks registers reserved by issue and not yet committed.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   Req0_Valid/Addr/Data, Req0_Ready   requester 0 handshake (Ready combinational)
//   Req1_Valid/Addr/Data, Req1_Ready   requester 1 handshake (Ready combinational)
//   Mark_Valid, Mark_Addr          issue-stage destination reservation
//   A3, WD, RegWrite               registered register-file write port
//   Busy                           per-register outstanding-write flags
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req0_Valid,
    input  logic [ADDR_W-1:0] Req0_Addr,
    input  logic [DATA_W-1:0] Req0_Data,
    output logic              Req0_Ready,
    input  logic              Req1_Valid,
    input  logic [ADDR_W-1:0] Req1_Addr,
    input  logic [DATA_W-1:0] Req1_Data,
    output logic              Req1_Ready,
    input  logic              Mark_Valid,
    input  logic [ADDR_W-1:0] Mark_Addr,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD,
    output logic              RegWrite,
    output logic [NREG-1:0]   Busy
);

    // ptr_q = 0: req0 wins a tie; ptr_q = 1: req1 wins a tie.
    logic              ptr_q, ptr_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              regwrite_q, regwrite_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic              grant0, grant1;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic [NREG-1:0]   set_vec, clr_vec;

    always_comb begin
        // No grants while in reset so nothing can transfer on the reset edge.
        grant0   = !RST && Req0_Valid && (!Req1_Valid || !ptr_q);
        grant1   = !RST && Req1_Valid && (!Req0_Valid ||  ptr_q);
        win_addr = grant1 ? Req1_Addr : Req0_Addr;
        win_data = grant1 ? Req1_Data : Req0_Data;

        ptr_d      = ptr_q;
        a3_d       = a3_q;
        wd_d       = wd_q;
        regwrite_d = 1'b0;
        if (grant0 || grant1) begin
            // Point at the requester that lost, so it wins the next tie.
            ptr_d      = grant0;
            a3_d       = win_addr;
            wd_d       = win_data;
            // x0 writes are accepted but never reach the register file.
            regwrite_d = (win_addr != '0);
        end

        set_vec = '0;
        if (Mark_Valid) begin
            set_vec[Mark_Addr] = 1'b1;
        end
        clr_vec = '0;
        if (regwrite_q) begin
            clr_vec[a3_q] = 1'b1;
        end
        // Set is applied after clear so a same-register collision stays busy.
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q      <= 1'b0;
            a3_q       <= '0;
            wd_q       <= '0;
            regwrite_q <= 1'b0;
            busy_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            a3_q       <= a3_d;
            wd_q       <= wd_d;
            regwrite_q <= regwrite_d;
            busy_q     <= busy_d;
        end
    end

    assign Req0_Ready = grant0;
    assign Req1_Ready = grant1;
    assign A3         = a3_q;
    assign WD         = wd_q;
    assign RegWrite   = regwrite_q;
    assign Busy       = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench with expected-write scoreboard
module tb_regfile_wb_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    logic              CLK = 1'b0;
    logic              RST;
    logic              Req0_Valid, Req1_Valid, Mark_Valid;
    logic [ADDR_W-1:0] Req0_Addr, Req1_Addr, Mark_Addr;
    logic [DATA_W-1:0] Req0_Data, Req1_Data;
    logic              Req0_Ready, Req1_Ready, RegWrite;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD;
    logic [NREG-1:0]   Busy;

    regfile_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREG(NREG)) dut (
        .CLK(CLK), .RST(RST),
        .Req0_Valid(Req0_Valid), .Req0_Addr(Req0_Addr), .Req0_Data(Req0_Data), .Req0_Ready(Req0_Ready),
        .Req1_Valid(Req1_Valid), .Req1_Addr(Req1_Addr), .Req1_Data(Req1_Data), .Req1_Ready(Req1_Ready),
        .Mark_Valid(Mark_Valid), .Mark_Addr(Mark_Addr),
        .A3(A3), .WD(WD), .RegWrite(RegWrite), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    // One entry per cycle: what the output stage must show in that cycle.
    typedef struct packed {
        logic              we;
        logic              aw;   // A3/WD are defined (not after an x0 slot)
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              exp_q[$];
    logic [NREG-1:0]   exp_busy;
    logic [ADDR_W-1:0] exp_a3;
    logic [DATA_W-1:0] exp_wd;
    logic              aw_ok;
    logic [DATA_W-1:0] mon_rf [NREG];
    int                checks   = 0;
    int                failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the current cycle, then advance one clock and queue the next expectation.
    task automatic tick(input logic e0, input logic e1);
        ent_t            ent, nent;
        logic [NREG-1:0] nbusy, clr, set;
        @(negedge CLK);
        ent = exp_q.pop_front();
        check("regwrite", RegWrite, ent.we);
        if (ent.aw) begin
            check("a3", A3, ent.a);
            check("wd", WD, ent.d);
        end
        check("busy", Busy, exp_busy);
        check("ready0", Req0_Ready, e0);
        check("ready1", Req1_Ready, e1);
        if (RegWrite === 1'b1) mon_rf[A3] = WD;

        if (RST) begin
            exp_a3 = '0; exp_wd = '0; aw_ok = 1'b1;
            nent   = '{we: 1'b0, aw: 1'b1, a: '0, d: '0};
            nbusy  = '0;
        end else begin
            if ((e0 && Req0_Valid) || (e1 && Req1_Valid)) begin
                exp_a3 = e0 ? Req0_Addr : Req1_Addr;
                exp_wd = e0 ? Req0_Data : Req1_Data;
                aw_ok  = (exp_a3 != 0);
                nent   = '{we: aw_ok, aw: aw_ok, a: exp_a3, d: exp_wd};
            end else begin
                nent   = '{we: 1'b0, aw: aw_ok, a: exp_a3, d: exp_wd};
            end
            clr = '0; set = '0;
            if (ent.we) clr[ent.a] = 1'b1;
            if (Mark_Valid) set[Mark_Addr] = 1'b1;
            nbusy    = (exp_busy & ~clr) | set;
            nbusy[0] = 1'b0;
        end
        @(posedge CLK);
        #1;
        exp_busy = nbusy;
        exp_q.push_back(nent);
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) mon_rf[i] = '0;
        RST = 1'b1;
        Req0_Valid = 1'b1; Req0_Addr = 5'd5; Req0_Data = 32'd99;
        Req1_Valid = 1'b0; Req1_Addr = '0;   Req1_Data = '0;
        Mark_Valid = 1'b0; Mark_Addr = '0;
        @(posedge CLK);
        #1;
        exp_busy = '0; exp_a3 = '0; exp_wd = '0; aw_ok = 1'b1;
        exp_q.push_back('{we: 1'b0, aw: 1'b1, a: '0, d: '0});

        // Reset held with req0 valid: no ready, no write.
        tick(0, 0); tick(0, 0); tick(0, 0);
        RST = 1'b0;
        tick(1, 0);
        Req0_Valid = 1'b0;
        tick(0, 0);                       // A3=5, WD=99 committed here

        // req1 stream (pointer now at req1 after req0 grant).
        Req1_Valid = 1'b1;
        Req1_Addr = 5'd1; Req1_Data = 32'd30; tick(0, 1);
        Req1_Addr = 5'd2; Req1_Data = 32'd15; tick(0, 1);
        Req1_Addr = 5'd3; Req1_Data = 32'd25; tick(0, 1);
        Req1_Valid = 1'b0;
        tick(0, 0); tick(0, 0);
        check("rf_x5", mon_rf[5], 32'd99);
        check("rf_x1", mon_rf[1], 32'd30);
        check("rf_x2", mon_rf[2], 32'd15);
        check("rf_x3", mon_rf[3], 32'd25);

        // Contention: both valid, grants alternate starting at req0.
        Req0_Valid = 1'b1; Req0_Addr = 5'd4; Req0_Data = 32'd5;
        Req1_Valid = 1'b1; Req1_Addr = 5'd5; Req1_Data = 32'd18;
        tick(1, 0);
        Req0_Addr = 5'd6; Req0_Data = 32'd4;
        tick(0, 1);
        Req1_Addr = 5'd7; Req1_Data = 32'd7;
        tick(1, 0);
        Req0_Valid = 1'b0;
        tick(0, 1);
        Req1_Valid = 1'b0;
        tick(0, 0); tick(0, 0);
        check("rf_x4", mon_rf[4], 32'd5);
        check("rf_x5b", mon_rf[5], 32'd18);
        check("rf_x6", mon_rf[6], 32'd4);
        check("rf_x7", mon_rf[7], 32'd7);

        // x0 write (with a Mark on x0 that must be ignored).
        Req0_Valid = 1'b1; Req0_Addr = 5'd0; Req0_Data = 32'd18;
        Mark_Valid = 1'b1; Mark_Addr = 5'd0;
        tick(1, 0);
        Mark_Valid = 1'b0;
        Req0_Addr = 5'd8; Req0_Data = 32'd1;
        Req1_Valid = 1'b1; Req1_Addr = 5'd9; Req1_Data = 32'd2;
        tick(0, 1);                       // pointer moved to req1
        Req1_Valid = 1'b0;
        tick(1, 0);
        Req0_Valid = 1'b0;
        tick(0, 0); tick(0, 0);
        check("rf_x0", mon_rf[0], 32'd0);
        check("busy0", Busy[0], 1'b0);
        check("rf_x9", mon_rf[9], 32'd2);

        // Scoreboard: Mark x3 at edge 0, write x3 transfers at edge 4.
        Mark_Valid = 1'b1; Mark_Addr = 5'd3;
        tick(0, 0);
        Mark_Valid = 1'b0;
        check("busy3_set", Busy[3], 1'b1);
        tick(0, 0); tick(0, 0); tick(0, 0);
        Req1_Valid = 1'b1; Req1_Addr = 5'd3; Req1_Data = 32'd25;
        tick(0, 1);
        Req1_Valid = 1'b0;
        check("busy3_commit_cycle", Busy[3], 1'b1);
        tick(0, 0);
        check("busy3_cleared", Busy[3], 1'b0);
        // Same-edge Mark and commit on x3 keeps it busy; x2 marked alongside.
        Mark_Valid = 1'b1; Mark_Addr = 5'd2;
        Req1_Valid = 1'b1; Req1_Addr = 5'd3; Req1_Data = 32'd44;
        tick(0, 1);
        Req1_Valid = 1'b0;
        Mark_Addr = 5'd3;
        tick(0, 0);                       // commit of x3 and Mark x3 share this edge
        Mark_Valid = 1'b0;
        check("busy3_set_wins", Busy[3], 1'b1);
        check("busy2_set", Busy[2], 1'b1);
        check("rf_x3b", mon_rf[3], 32'd44);

        // Reset mid-write: pointer first moved to req1, x6 reserved.
        Req0_Valid = 1'b1; Req0_Addr = 5'd10; Req0_Data = 32'd3;
        tick(1, 0);
        Req0_Valid = 1'b0;
        Mark_Valid = 1'b1; Mark_Addr = 5'd6;
        tick(0, 0);
        Mark_Valid = 1'b0;
        check("busy6_set", Busy[6], 1'b1);
        Req0_Valid = 1'b1; Req0_Addr = 5'd6; Req0_Data = 32'd4;
        RST = 1'b1;
        tick(0, 0);
        RST = 1'b0;
        check("busy_after_rst", Busy, {NREG{1'b0}});
        check("regwrite_after_rst", RegWrite, 1'b0);
        Req1_Valid = 1'b1; Req1_Addr = 5'd7; Req1_Data = 32'd9;
        tick(1, 0);                       // pointer back at req0
        Req0_Valid = 1'b0;
        tick(0, 1);
        Req1_Valid = 1'b0;
        tick(0, 0); tick(0, 0);
        check("rf_x6_after_rst", mon_rf[6], 32'd4);
        check("rf_x7_after_rst", mon_rf[7], 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (A3/WD/RegWrite) between two write-back requesters: req0 = ALU result path, req1 = data-memory load path.
- Uses round-robin arbitration with a valid/ready handshake.
- Registers the winning write one cycle before it reaches the register file.
- Keeps a pending-write scoreboard (Busy) so issue logic can stall on registers that have outstanding writes.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NREG, 32, number of architectural registers; Busy width; must equal 2**ADDR_W.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- Req0_Valid  input  1  requester 0 has a write pending.
- Req0_Addr  input  ADDR_W  requester 0 destination register.
- Req0_Data  input  DATA_W  requester 0 write data.
- Req0_Ready  output  1  requester 0 write accepted this cycle (combinational).
- Req1_Valid  input  1  requester 1 has a write pending.
- Req1_Addr  input  ADDR_W  requester 1 destination register.
- Req1_Data  input  DATA_W  requester 1 write data.
- Req1_Ready  output  1  requester 1 write accepted this cycle (combinational).
- Mark_Valid  input  1  issue stage reserves a destination register.
- Mark_Addr  input  ADDR_W  register being reserved.
- A3  output  ADDR_W  register-file write address (registered).
- WD  output  DATA_W  register-file write data (registered).
- RegWrite  output  1  register-file write enable (registered).
- Busy  output  NREG  bit i = 1 while register i has an outstanding write.

Behaviour:
- Reset, synchronous: RegWrite=0, A3=0, WD=0, Busy=0, priority pointer = req0. Reset applied mid-operation discards any in-flight write; RegWrite is 0 in the cycle after the reset edge. Ready outputs are 0 while RST=1.
- Arbitration, combinational, within a cycle:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester at the priority pointer is granted.
  - Neither valid: no grant.
- ReqN_Ready = grant to N. At most one Ready is high per cycle.
- Handshake: a transfer occurs at an edge where Valid and Ready are both 1. The requester holds Valid/Addr/Data stable until Ready. A non-granted requester simply waits; nothing is lost.
- Priority pointer: after any transfer it points to the requester that was *not* granted. It is unchanged on idle cycles. Worst-case wait with both requesters continuously valid is 1 cycle.
- Output stage, 1-cycle latency: a transfer at edge k sets A3/WD to the granted Addr/Data and RegWrite=1 during cycle k+1. The register file writes at edge k+1. With no transfer at edge k, RegWrite=0 in cycle k+1, and A3/WD hold their previous values.
- Writes to x0:
  - They are accepted (Ready=1, pointer updates), but RegWrite stays 0 for that slot.
  - Busy[0] is hardwired 0; Mark to x0 is ignored.
- Scoreboard:
  - Mark_Valid at edge k sets Busy[Mark_Addr] from cycle k+1.
  - A committed write, i.e. RegWrite=1 at edge k+1, clears Busy[A3] from cycle k+2. At that point the register-file content is already updated.
  - Set and clear of the same register at the same edge: set wins (Busy=1).
  - Set and clear of different registers at the same edge both apply.
- Throughput: one write per cycle sustained. No internal buffering beyond the output register, so there is no full/empty condition.

Test Plan:
- Reset: RST=1 for 3 cycles with Req0_Valid=1 (Addr=5, Data=99) -> Ready0=0, RegWrite=0, Busy=0. After release, the first grant goes to req0; cycle+1 shows A3=5, WD=99, RegWrite=1.
- Single requester stream: req1 writes x1=30, x2=15, x3=25 on consecutive cycles -> Ready1=1 every cycle; RegWrite=1 for 3 cycles, lagging by 1 cycle with matching A3/WD. A monitor-modelled register file reads back 30/15/25.
- Contention: both valid continuously (req0: x4=5, x6=4; req1: x5=18, x7=7) -> grants alternate req0, req1, req0, req1. Each requester waits at most 1 cycle and data is never corrupted.
- x0 write: req0 Addr=0, Data=18 -> Ready0=1, RegWrite stays 0, pointer moves to req1, x0 reads 0.
- Scoreboard: Mark x3 at edge 0 -> Busy[3]=1 from cycle 1. req1 write x3=25 transfers at edge 4 -> RegWrite in cycle 5, Busy[3]=0 from cycle 6. A same-edge Mark and commit on x3 keeps Busy[3]=1.
- Reset mid-write: assert RST in the cycle a transfer of x6=4 occurs with Busy[6]=1 -> RegWrite=0 in the following cycle, Busy all 0, pointer back to req0.
